// File: rtl/fetch_pc.sv
// fetch_pc: instruction fetch program counter.
//
// Produces the fetch byte address for the instruction memory and decides each
// cycle where fetch goes next. Priority while enabled:
//   flush > stall[0] > live branch > pending redirect > sequential (pc + 4).
// A branch that arrives while fetch is stalled cannot be applied, so its
// target is parked in a pending register and applied on the first cycle
// after the stall releases, unless something of higher priority wins first.
//
// Ports:
//   clk                      - clock, all state changes on the rising edge
//   rst                      - synchronous active-high reset
//   stall[5:0]               - pipeline stall vector, only stall[0] is used
//   flush                    - redirect fetch to new_pc (beats stall)
//   new_pc[31:0]             - flush target address
//   branch_flag_i            - branch taken, from decode
//   branch_target_address_i  - branch target address
//   pc[31:0]                 - registered fetch address
//   ce                       - registered instruction memory chip enable
//   redirect_pending_o       - registered: a stalled branch is waiting
//   fetch_misalign_o         - registered: pc is not word aligned
//
// Configuration macro: FETCH_ALIGN_CHECK_EN
//   defined   -> fetch_misalign_o flags any enabled pc with pc[1:0] != 0
//   undefined -> fetch_misalign_o is tied to 0, no alignment logic exists

module fetch_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic [31:0] pc,
  output logic        ce,
  output logic        redirect_pending_o,
  output logic        fetch_misalign_o
);

  logic        pend_valid;
  logic [31:0] pend_target;

  logic [31:0] pc_next;
  logic        pend_valid_next;
  logic [31:0] pend_target_next;

  // Only the fetch hold bit of the stall vector matters to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // Next-state selection. While ce is still 0 (first cycle out of reset) the
  // pc is pinned at 0 so the first enabled fetch address is 0x00000000.
  always_comb begin
    pc_next          = pc;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;

    if (!ce) begin
      pc_next = 32'h0000_0000;
    end else if (flush) begin
      pc_next         = new_pc;
      pend_valid_next = 1'b0;
    end else if (stall[0]) begin
      // Hold; a later branch in the same stall replaces an earlier one.
      if (branch_flag_i) begin
        pend_valid_next  = 1'b1;
        pend_target_next = branch_target_address_i;
      end
    end else if (branch_flag_i) begin
      pc_next         = branch_target_address_i;
      pend_valid_next = 1'b0;
    end else if (pend_valid) begin
      pc_next         = pend_target;
      pend_valid_next = 1'b0;
    end else begin
      // Natural 32-bit overflow gives the wrap from 0xFFFFFFFC to 0.
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce          <= 1'b0;
      pc          <= 32'h0000_0000;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0000_0000;
    end else begin
      ce          <= 1'b1;
      pc          <= pc_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
    end
  end

  assign redirect_pending_o = pend_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  // Registered alongside pc so the flag lines up with the address it
  // describes. ce is always 1 after a non-reset edge, and pc_next is 0
  // while ce was 0, so no explicit ce term is needed here.
  logic misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= |pc_next[1:0];
    end
  end

  assign fetch_misalign_o = misalign;
`else
  assign fetch_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: scoreboard bench for fetch_pc.
// The driver applies one cycle of stimulus at each falling edge and pushes
// the values the outputs must hold after the following rising edge; the
// monitor pops one entry per rising edge and compares.

module tb_fetch_pc;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc;
  logic        ce;
  logic        redirect_pending_o;
  logic        fetch_misalign_o;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
    int          step;
  } exp_t;

  exp_t sb[$];
  int   testsRun   = 0;
  int   testsFailed = 0;
  int   stepNum    = 0;

  fetch_pc dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce),
    .redirect_pending_o      (redirect_pending_o),
    .fetch_misalign_o        (fetch_misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and record what must appear after the next edge.
  // stall[5:1] gets random noise to show the block ignores those bits.
  task automatic applyStimulus(input logic r, input logic s0, input logic fl,
                               input logic [31:0] npc, input logic br,
                               input logic [31:0] tgt, input logic [31:0] epc,
                               input logic ece, input logic epend);
    exp_t e;
    @(negedge clk);
    rst                     = r;
    stall                   = {5'($urandom_range(0, 31)), s0};
    flush                   = fl;
    new_pc                  = npc;
    branch_flag_i           = br;
    branch_target_address_i = tgt;
    stepNum++;
    e.pc   = epc;
    e.ce   = ece;
    e.pend = epend;
`ifdef FETCH_ALIGN_CHECK_EN
    e.mis  = ece && (epc[1:0] != 2'b00);
`else
    e.mis  = 1'b0;
`endif
    e.step = stepNum;
    sb.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput($sformatf("step%0d.pc", e.step), pc, e.pc);
        checkOutput($sformatf("step%0d.ce", e.step), {31'd0, ce}, {31'd0, e.ce});
        checkOutput($sformatf("step%0d.pend", e.step), {31'd0, redirect_pending_o}, {31'd0, e.pend});
        checkOutput($sformatf("step%0d.misalign", e.step), {31'd0, fetch_misalign_o}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    rst                     = 1'b1;
    stall                   = 6'd0;
    flush                   = 1'b0;
    new_pc                  = 32'd0;
    branch_flag_i           = 1'b0;
    branch_target_address_i = 32'd0;

    // Reset for three cycles, then sequential fetch from 0.
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h44, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h4, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h8, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'hC, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h10, 1, 0);

    // Unstalled branch at 0x10.
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 32'h100, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h104, 1, 0);

    // Get to 0x20, stall three cycles with a branch in the first one.
    applyStimulus(0, 0, 1, 32'h20, 0, 0, 32'h20, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 32'h200, 32'h20, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h20, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h20, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h200, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h204, 1, 0);

    // Second branch in the same stall replaces the first.
    applyStimulus(0, 1, 0, 0, 1, 32'h300, 32'h204, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 32'h400, 32'h204, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h400, 1, 0);

    // Live branch beats a pending target.
    applyStimulus(0, 1, 0, 0, 1, 32'h500, 32'h400, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h600, 32'h600, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h604, 1, 0);

    // Flush during stall with a pending redirect discards the redirect.
    applyStimulus(0, 1, 0, 0, 1, 32'h700, 32'h604, 1, 1);
    applyStimulus(0, 1, 1, 32'h8000_0180, 0, 0, 32'h8000_0180, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h8000_0184, 1, 0);

    // Wrap at the top of the address space.
    applyStimulus(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);

    // Reset mid-stall with a pending redirect and every other request active.
    applyStimulus(0, 1, 0, 0, 1, 32'h900, 32'h0, 1, 1);
    applyStimulus(1, 1, 1, 32'h1234_5678, 1, 32'hA00, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h4, 1, 0);

    // Misaligned branch target, then sequential, then back to aligned.
    applyStimulus(0, 0, 0, 0, 1, 32'h102, 32'h102, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h106, 1, 0);
    applyStimulus(0, 0, 1, 32'h200, 0, 0, 32'h200, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h204, 1, 0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
